nes_scaler_timing: RTL

Parametrised successor to the fixed 1080p NES DisplayPort output stage. It generates video timing in the pixel clock domain and upscales a SRC_W×SRC_H framebuffer by an integer factor, centred in the active area with a border colour. Framebuffer reads use a configurable read latency, and sync/enable outputs are delay-matched to the returned pixel. An optional scanline-dim flag is provided. It sits between the PPU framebuffer read port and the palette/DP transmitter.

---
 rtl/nes_video_pkg.sv | 45 ++++
 rtl/nes_axis_scaler.sv | 59 +++++
 rtl/nes_scaler_timing.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/nes_video_pkg.sv
// Shared video timing constants, NES source geometry and helpers for the
// scaler/timing output stage.
package nes_video_pkg;

   localparam int H_ACTIVE_1080 = 1920;
   localparam int H_FP_1080     = 88;
   localparam int H_SYNC_1080   = 44;
   localparam int H_BP_1080     = 148;
   localparam int V_ACTIVE_1080 = 1080;
   localparam int V_FP_1080     = 4;
   localparam int V_SYNC_1080   = 5;
   localparam int V_BP_1080     = 36;

   localparam int H_ACTIVE_720  = 1280;
   localparam int H_FP_720      = 110;
   localparam int H_SYNC_720    = 40;
   localparam int H_BP_720      = 220;
   localparam int V_ACTIVE_720  = 720;
   localparam int V_FP_720      = 5;
   localparam int V_SYNC_720    = 5;
   localparam int V_BP_720      = 20;

   localparam int NES_SRC_W = 256;
   localparam int NES_SRC_H = 240;

   // Sideband flags that travel alongside a framebuffer read.
   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
      logic win;
      logic dim;
      logic fstart;
      logic lstart;
   } vid_flags_t;

   function automatic int center_off(input int active, input int src, input int scale);
      return (active - src * scale) / 2;
   endfunction

   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nes_axis_scaler.sv
// One axis of the upscaler: tracks the sub-pixel phase and source coordinate
// for a position counter without using a divider.
module nes_axis_scaler
   import nes_video_pkg::*;
#(
   parameter int OFF   = 0,
   parameter int SRC   = 256,
   parameter int SCALE = 4,
   parameter int TOTAL = 2200
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [bits_for(TOTAL)-1:0]    pos,
   input  logic                          step,
   input  logic                          wrap,
   output logic [bits_for(SRC)-1:0]      coord,
   output logic [bits_for(SCALE)-1:0]    sub,
   output logic                          in_win
);

   localparam int PW      = bits_for(TOTAL);
   localparam int CW      = bits_for(SRC);
   localparam int SW      = bits_for(SCALE);
   localparam int WIN_END = OFF + SRC * SCALE;
   localparam int CLR_POS = (OFF > 0) ? OFF - 1 : TOTAL - 1;

   logic lo_ok;
   logic clear;

   if (OFF == 0) begin : g_lo_zero
      assign lo_ok = 1'b1;
   end else begin : g_lo_cmp
      assign lo_ok = (pos >= PW'(OFF));
   end

   assign in_win = lo_ok && (pos < PW'(WIN_END));

   // Clearing on the axis wrap as well leaves no stale phase from a previous line/frame.
   assign clear = step && (wrap || (pos == PW'(CLR_POS)));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub   <= '0;
         coord <= '0;
      end else if (clear) begin
         sub   <= '0;
         coord <= '0;
      end else if (step && in_win) begin
         if (sub == SW'(SCALE - 1)) begin
            sub   <= '0;
            coord <= coord + CW'(1);
         end else begin
            sub <= sub + SW'(1);
         end
      end
   end

endmodule

// File: rtl/nes_scaler_timing.sv
// Pixel-clock video timing generator with integer upscaling of a framebuffer,
// centred with a border colour; sideband is delay-matched to the read latency.
module nes_scaler_timing
   import nes_video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_1080,
   parameter int H_FP     = H_FP_1080,
   parameter int H_SYNC   = H_SYNC_1080,
   parameter int H_BP     = H_BP_1080,
   parameter int V_ACTIVE = V_ACTIVE_1080,
   parameter int V_FP     = V_FP_1080,
   parameter int V_SYNC   = V_SYNC_1080,
   parameter int V_BP     = V_BP_1080,
   parameter int SRC_W    = NES_SRC_W,
   parameter int SRC_H    = NES_SRC_H,
   parameter int SCALE    = 4,
   parameter int RD_LAT   = 1,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int PIX_W    = 6
) (
   input  logic                                          clk_pixel,
   input  logic                                          rst_pixel_n,
   input  logic [PIX_W-1:0]                              border_idx,
   input  logic                                          dim_en,
   output logic                                          fb_rd_en,
   output logic [bits_for(SRC_H)+bits_for(SRC_W)-1:0]    fb_raddr,
   input  logic [PIX_W-1:0]                              fb_rdata,
   output logic [PIX_W-1:0]                              pix_idx,
   output logic                                          pix_win,
   output logic                                          dim,
   output logic                                          de,
   output logic                                          hsync,
   output logic                                          vsync,
   output logic                                          frame_start,
   output logic                                          line_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int X_OFF    = center_off(H_ACTIVE, SRC_W, SCALE);
   localparam int Y_OFF    = center_off(V_ACTIVE, SRC_H, SCALE);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int XW       = bits_for(H_TOTAL);
   localparam int YW       = bits_for(V_TOTAL);
   localparam int FXW      = bits_for(SRC_W);
   localparam int FYW      = bits_for(SRC_H);
   localparam int SUBW     = bits_for(SCALE);
   localparam bit DIM_OK   = (SCALE >= 2);

   localparam vid_flags_t FLAGS_RST = '{
      de: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL, win: 1'b0,
      dim: 1'b0, fstart: 1'b0, lstart: 1'b0
   };

   if (SRC_W * SCALE > H_ACTIVE || SRC_H * SCALE > V_ACTIVE) begin : g_bad_window
      $error("nes_scaler_timing: scaled source does not fit the active area");
   end
   if (RD_LAT < 1 || RD_LAT > 4 || SCALE < 1) begin : g_bad_lat
      $error("nes_scaler_timing: RD_LAT must be 1..4 and SCALE at least 1");
   end

   logic [XW-1:0]   sx;
   logic [YW-1:0]   sy;
   logic            line_wrap;
   logic            frame_wrap;
   logic [FXW-1:0]  fx;
   logic [FYW-1:0]  fy;
   logic [SUBW-1:0] hsub_unused;
   logic [SUBW-1:0] vsub;
   logic            x_win;
   logic            y_win;
   vid_flags_t      s0;
   vid_flags_t      pipe [RD_LAT];

   assign line_wrap  = (sx == XW'(H_TOTAL - 1));
   assign frame_wrap = line_wrap && (sy == YW'(V_TOTAL - 1));

   always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
      if (!rst_pixel_n) begin
         sx <= '0;
         sy <= '0;
      end else if (line_wrap) begin
         sx <= '0;
         sy <= frame_wrap ? '0 : sy + YW'(1);
      end else begin
         sx <= sx + XW'(1);
      end
   end

   nes_axis_scaler #(
      .OFF   (X_OFF),
      .SRC   (SRC_W),
      .SCALE (SCALE),
      .TOTAL (H_TOTAL)
   ) u_x_axis (
      .clk    (clk_pixel),
      .rst_n  (rst_pixel_n),
      .pos    (sx),
      .step   (1'b1),
      .wrap   (line_wrap),
      .coord  (fx),
      .sub    (hsub_unused),
      .in_win (x_win)
   );

   nes_axis_scaler #(
      .OFF   (Y_OFF),
      .SRC   (SRC_H),
      .SCALE (SCALE),
      .TOTAL (V_TOTAL)
   ) u_y_axis (
      .clk    (clk_pixel),
      .rst_n  (rst_pixel_n),
      .pos    (sy),
      .step   (line_wrap),
      .wrap   (frame_wrap),
      .coord  (fy),
      .sub    (vsub),
      .in_win (y_win)
   );

   always_comb begin
      s0        = '0;
      s0.de     = (sx < XW'(H_ACTIVE)) && (sy < YW'(V_ACTIVE));
      s0.hsync  = ((sx >= XW'(HS_START)) && (sx < XW'(HS_END))) ? HS_POL : ~HS_POL;
      s0.vsync  = ((sy >= YW'(VS_START)) && (sy < YW'(VS_END))) ? VS_POL : ~VS_POL;
      s0.win    = x_win && y_win;
      s0.dim    = s0.win && dim_en && DIM_OK && (vsub == SUBW'(SCALE - 1));
      s0.fstart = (sx == '0) && (sy == '0);
      s0.lstart = (sx == '0);
   end

   // The counters sit at (0,0) during reset, which can be inside the window.
   assign fb_rd_en = s0.win && rst_pixel_n;
   assign fb_raddr = {fy, fx};

   // NOTE: the short delay line is reset so syncs and pulses are clean from the first output edge.
   always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
      if (!rst_pixel_n) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= FLAGS_RST;
      end else begin
         pipe[0] <= s0;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
      if (!rst_pixel_n) begin
         de          <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         pix_win     <= 1'b0;
         dim         <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         pix_idx     <= '0;
      end else begin
         de          <= pipe[RD_LAT-1].de;
         hsync       <= pipe[RD_LAT-1].hsync;
         vsync       <= pipe[RD_LAT-1].vsync;
         pix_win     <= pipe[RD_LAT-1].win;
         dim         <= pipe[RD_LAT-1].dim;
         frame_start <= pipe[RD_LAT-1].fstart;
         line_start  <= pipe[RD_LAT-1].lstart;
         // border_idx is taken live here rather than carried through the delay line.
         pix_idx     <= pipe[RD_LAT-1].win ? fb_rdata : border_idx;
      end
   end

endmodule
